// File: rtl/mmu_tlb_arbiter_pkg.sv
// Shared types and widths for the TLB search-port arbiter.
package mmu_tlb_arbiter_pkg;

  localparam int unsigned VA_W    = 32;
  localparam int unsigned VPPN_W  = 19;
  localparam int unsigned ASID_W  = 10;
  localparam int unsigned PPN_W   = 20;
  localparam int unsigned PS_W    = 6;
  localparam int unsigned PLV_W   = 2;
  localparam int unsigned MAT_W   = 2;
  localparam int unsigned NUM_REQ = 3;

  typedef enum logic [1:0] {
    REQ_IF   = 2'd0,
    REQ_MEM  = 2'd1,
    REQ_SRCH = 2'd2
  } req_id_e;

  // Index-independent part of a search result; the index is appended per TLBNUM.
  typedef struct packed {
    logic             found;
    logic [PPN_W-1:0] ppn;
    logic [PS_W-1:0]  ps;
    logic [PLV_W-1:0] plv;
    logic [MAT_W-1:0] mat;
    logic             d;
    logic             v;
  } tlb_res_t;

  localparam int unsigned TLB_RES_FIXED_W = $bits(tlb_res_t);

  function automatic int unsigned tlb_res_w(input int unsigned tlbnum);
    return TLB_RES_FIXED_W + $clog2(tlbnum);
  endfunction

endpackage

// File: rtl/mmu_resp_slot.sv
// One-entry response buffer: valid bit with reset, payload held while valid.
module mmu_resp_slot #(
  parameter int unsigned W = 37
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic         consume_i,
  input  logic         kill_i,
  input  logic [W-1:0] data_i,
  output logic         valid_o,
  output logic [W-1:0] data_o
);

  logic         valid_q;
  logic         valid_d;
  logic [W-1:0] data_q;

  // kill wins over a same-cycle load
  always_comb begin
    valid_d = valid_q;
    if (load_i) begin
      valid_d = 1'b1;
    end else if (consume_i) begin
      valid_d = 1'b0;
    end
    if (kill_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (load_i) begin
      data_q <= data_i;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/mmu_tlb_arbiter.sv
// Arbitrates IF, MEM and tlbsrch onto the single TLB search port and buffers
// each requester's result in its own one-entry slot.
module mmu_tlb_arbiter
  import mmu_tlb_arbiter_pkg::*;
#(
  parameter int unsigned TLBNUM = 16
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic [ASID_W-1:0]           csr_asid,
  input  logic                        tlb_busy,
  input  logic                        flush,

  input  logic                        if_req_valid,
  input  logic [VA_W-1:0]             if_va,
  output logic                        if_req_ready,
  output logic                        if_resp_valid,
  input  logic                        if_resp_ready,
  output logic                        if_resp_found,
  output logic [$clog2(TLBNUM)-1:0]   if_resp_index,
  output logic [PPN_W-1:0]            if_resp_ppn,
  output logic [PS_W-1:0]             if_resp_ps,
  output logic [PLV_W-1:0]            if_resp_plv,
  output logic [MAT_W-1:0]            if_resp_mat,
  output logic                        if_resp_d,
  output logic                        if_resp_v,

  input  logic                        mem_req_valid,
  input  logic [VA_W-1:0]             mem_va,
  output logic                        mem_req_ready,
  output logic                        mem_resp_valid,
  input  logic                        mem_resp_ready,
  output logic                        mem_resp_found,
  output logic [$clog2(TLBNUM)-1:0]   mem_resp_index,
  output logic [PPN_W-1:0]            mem_resp_ppn,
  output logic [PS_W-1:0]             mem_resp_ps,
  output logic [PLV_W-1:0]            mem_resp_plv,
  output logic [MAT_W-1:0]            mem_resp_mat,
  output logic                        mem_resp_d,
  output logic                        mem_resp_v,

  input  logic                        srch_req_valid,
  input  logic [VA_W-1:0]             srch_va,
  output logic                        srch_req_ready,
  output logic                        srch_resp_valid,
  input  logic                        srch_resp_ready,
  output logic                        srch_resp_found,
  output logic [$clog2(TLBNUM)-1:0]   srch_resp_index,
  output logic [PPN_W-1:0]            srch_resp_ppn,
  output logic [PS_W-1:0]             srch_resp_ps,
  output logic [PLV_W-1:0]            srch_resp_plv,
  output logic [MAT_W-1:0]            srch_resp_mat,
  output logic                        srch_resp_d,
  output logic                        srch_resp_v,

  output logic [VPPN_W-1:0]           s_vppn,
  output logic                        s_va_bit12,
  output logic [ASID_W-1:0]           s_asid,
  input  logic                        s_found,
  input  logic [$clog2(TLBNUM)-1:0]   s_index,
  input  logic [PPN_W-1:0]            s_ppn,
  input  logic [PS_W-1:0]             s_ps,
  input  logic [PLV_W-1:0]            s_plv,
  input  logic [MAT_W-1:0]            s_mat,
  input  logic                        s_d,
  input  logic                        s_v
);

  localparam int unsigned IDX_W = $clog2(TLBNUM);
  localparam int unsigned RES_W = tlb_res_w(TLBNUM);

  logic [NUM_REQ-1:0] req_valid_c;
  logic [NUM_REQ-1:0] resp_ready_c;
  logic [NUM_REQ-1:0] resp_valid_c;
  logic [NUM_REQ-1:0] kill_c;
  logic [NUM_REQ-1:0] elig_c;
  logic [NUM_REQ-1:0] grant_c;
  req_id_e            last_q;
  req_id_e            last_d;
  logic [VA_W-1:12]   va_sel_c;
  tlb_res_t           s_res_c;
  logic [RES_W-1:0]   slot_in_c;
  logic [RES_W-1:0]   slot_data [NUM_REQ];
  tlb_res_t           if_res;
  tlb_res_t           mem_res;
  tlb_res_t           srch_res;
  logic               unused_va_low;

  assign req_valid_c  = {srch_req_valid, mem_req_valid, if_req_valid};
  assign resp_ready_c = {srch_resp_ready, mem_resp_ready, if_resp_ready};
  assign kill_c       = {1'b0, flush, flush};

  // A slot can accept a new result when empty or drained this same cycle.
  assign elig_c = req_valid_c & (~resp_valid_c | resp_ready_c)
                & {NUM_REQ{~tlb_busy & ~flush}};

  // SRCH first; IF/MEM tie goes to whichever did not win last.
  always_comb begin
    grant_c = '0;
    last_d  = last_q;
    if (elig_c[REQ_SRCH]) begin
      grant_c[REQ_SRCH] = 1'b1;
    end else if (elig_c[REQ_IF] && (!elig_c[REQ_MEM] || last_q == REQ_MEM)) begin
      grant_c[REQ_IF] = 1'b1;
    end else if (elig_c[REQ_MEM]) begin
      grant_c[REQ_MEM] = 1'b1;
    end
    if (grant_c[REQ_IF]) begin
      last_d = REQ_IF;
    end else if (grant_c[REQ_MEM]) begin
      last_d = REQ_MEM;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      last_q <= REQ_MEM;
    end else begin
      last_q <= last_d;
    end
  end

  assign if_req_ready   = grant_c[REQ_IF];
  assign mem_req_ready  = grant_c[REQ_MEM];
  assign srch_req_ready = grant_c[REQ_SRCH];

  // IF address doubles as the idle value of the search port.
  always_comb begin
    va_sel_c = if_va[VA_W-1:12];
    if (grant_c[REQ_SRCH]) begin
      va_sel_c = srch_va[VA_W-1:12];
    end else if (grant_c[REQ_MEM]) begin
      va_sel_c = mem_va[VA_W-1:12];
    end
  end

  assign s_vppn        = va_sel_c[VA_W-1:13];
  assign s_va_bit12    = va_sel_c[12];
  assign s_asid        = csr_asid;
  assign unused_va_low = ^{if_va[11:0], mem_va[11:0], srch_va[11:0]};

  assign s_res_c = '{found: s_found, ppn: s_ppn, ps: s_ps, plv: s_plv,
                     mat: s_mat, d: s_d, v: s_v};
  assign slot_in_c = {IDX_W'(s_index), s_res_c};

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_slot
    mmu_resp_slot #(.W(RES_W)) u_slot (
      .clk       (clk),
      .rst_n     (resetn),
      .load_i    (grant_c[g]),
      .consume_i (resp_ready_c[g]),
      .kill_i    (kill_c[g]),
      .data_i    (slot_in_c),
      .valid_o   (resp_valid_c[g]),
      .data_o    (slot_data[g])
    );
  end

  assign if_resp_valid   = resp_valid_c[REQ_IF];
  assign mem_resp_valid  = resp_valid_c[REQ_MEM];
  assign srch_resp_valid = resp_valid_c[REQ_SRCH];

  assign {if_resp_index, if_res}     = slot_data[REQ_IF];
  assign {mem_resp_index, mem_res}   = slot_data[REQ_MEM];
  assign {srch_resp_index, srch_res} = slot_data[REQ_SRCH];

  assign if_resp_found   = if_res.found;
  assign if_resp_ppn     = if_res.ppn;
  assign if_resp_ps      = if_res.ps;
  assign if_resp_plv     = if_res.plv;
  assign if_resp_mat     = if_res.mat;
  assign if_resp_d       = if_res.d;
  assign if_resp_v       = if_res.v;

  assign mem_resp_found  = mem_res.found;
  assign mem_resp_ppn    = mem_res.ppn;
  assign mem_resp_ps     = mem_res.ps;
  assign mem_resp_plv    = mem_res.plv;
  assign mem_resp_mat    = mem_res.mat;
  assign mem_resp_d      = mem_res.d;
  assign mem_resp_v      = mem_res.v;

  assign srch_resp_found = srch_res.found;
  assign srch_resp_ppn   = srch_res.ppn;
  assign srch_resp_ps    = srch_res.ps;
  assign srch_resp_plv   = srch_res.plv;
  assign srch_resp_mat   = srch_res.mat;
  assign srch_resp_d     = srch_res.d;
  assign srch_resp_v     = srch_res.v;

endmodule

// File: tb/tb_mmu_tlb_arbiter.sv
// Bench for mmu_tlb_arbiter: directed vector table, reset/miss sequence, and
// randomized traffic against a slot-level reference model.
module tb_mmu_tlb_arbiter;

  localparam int unsigned TLBNUM = 16;

  logic        clk;
  logic        resetn;
  logic [9:0]  csr_asid;
  logic        tlb_busy;
  logic        flush;
  logic        if_req_valid, mem_req_valid, srch_req_valid;
  logic [31:0] if_va, mem_va, srch_va;
  logic        if_req_ready, mem_req_ready, srch_req_ready;
  logic        if_resp_valid, mem_resp_valid, srch_resp_valid;
  logic        if_resp_ready, mem_resp_ready, srch_resp_ready;
  logic        if_resp_found, mem_resp_found, srch_resp_found;
  logic [3:0]  if_resp_index, mem_resp_index, srch_resp_index;
  logic [19:0] if_resp_ppn, mem_resp_ppn, srch_resp_ppn;
  logic [5:0]  if_resp_ps, mem_resp_ps, srch_resp_ps;
  logic [1:0]  if_resp_plv, mem_resp_plv, srch_resp_plv;
  logic [1:0]  if_resp_mat, mem_resp_mat, srch_resp_mat;
  logic        if_resp_d, mem_resp_d, srch_resp_d;
  logic        if_resp_v, mem_resp_v, srch_resp_v;
  logic [18:0] s_vppn;
  logic        s_va_bit12;
  logic [9:0]  s_asid;
  logic        s_found;
  logic [3:0]  s_index;
  logic [19:0] s_ppn;
  logic [5:0]  s_ps;
  logic [1:0]  s_plv, s_mat;
  logic        s_d, s_v;

  logic [19:0] tb_salt;
  logic        tb_miss;

  int n_err;
  int n_chk;

  typedef struct packed {
    logic        found;
    logic [3:0]  index;
    logic [19:0] ppn;
    logic [5:0]  ps;
    logic [1:0]  plv;
    logic [1:0]  mat;
    logic        d;
    logic        v;
  } res_t;

  typedef struct {
    logic [2:0] rv;
    logic [2:0] rr;
    logic       busy;
    logic       flush;
    logic [2:0] gnt;
    logic [2:0] vld;
  } vec_t;

  mmu_tlb_arbiter #(.TLBNUM(TLBNUM)) dut (
    .clk(clk), .resetn(resetn), .csr_asid(csr_asid), .tlb_busy(tlb_busy), .flush(flush),
    .if_req_valid(if_req_valid), .if_va(if_va), .if_req_ready(if_req_ready),
    .if_resp_valid(if_resp_valid), .if_resp_ready(if_resp_ready),
    .if_resp_found(if_resp_found), .if_resp_index(if_resp_index), .if_resp_ppn(if_resp_ppn),
    .if_resp_ps(if_resp_ps), .if_resp_plv(if_resp_plv), .if_resp_mat(if_resp_mat),
    .if_resp_d(if_resp_d), .if_resp_v(if_resp_v),
    .mem_req_valid(mem_req_valid), .mem_va(mem_va), .mem_req_ready(mem_req_ready),
    .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready),
    .mem_resp_found(mem_resp_found), .mem_resp_index(mem_resp_index), .mem_resp_ppn(mem_resp_ppn),
    .mem_resp_ps(mem_resp_ps), .mem_resp_plv(mem_resp_plv), .mem_resp_mat(mem_resp_mat),
    .mem_resp_d(mem_resp_d), .mem_resp_v(mem_resp_v),
    .srch_req_valid(srch_req_valid), .srch_va(srch_va), .srch_req_ready(srch_req_ready),
    .srch_resp_valid(srch_resp_valid), .srch_resp_ready(srch_resp_ready),
    .srch_resp_found(srch_resp_found), .srch_resp_index(srch_resp_index), .srch_resp_ppn(srch_resp_ppn),
    .srch_resp_ps(srch_resp_ps), .srch_resp_plv(srch_resp_plv), .srch_resp_mat(srch_resp_mat),
    .srch_resp_d(srch_resp_d), .srch_resp_v(srch_resp_v),
    .s_vppn(s_vppn), .s_va_bit12(s_va_bit12), .s_asid(s_asid),
    .s_found(s_found), .s_index(s_index), .s_ppn(s_ppn), .s_ps(s_ps),
    .s_plv(s_plv), .s_mat(s_mat), .s_d(s_d), .s_v(s_v)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in TLB array: result is a fixed function of the searched page and a salt.
  function automatic res_t tlb_model(input logic [18:0] vppn, input logic [19:0] salt,
                                     input logic miss);
    res_t r;
    r.found = ~miss;
    r.index = vppn[3:0] ^ salt[3:0];
    r.ppn   = {1'b0, vppn} ^ salt;
    r.ps    = vppn[0] ? 6'd21 : 6'd12;
    r.plv   = vppn[2:1];
    r.mat   = salt[1:0];
    r.d     = vppn[4];
    r.v     = vppn[5];
    return r;
  endfunction

  res_t tlb_r;
  always_comb begin
    tlb_r   = tlb_model(s_vppn, tb_salt, tb_miss);
    s_found = tlb_r.found;
    s_index = tlb_r.index;
    s_ppn   = tlb_r.ppn;
    s_ps    = tlb_r.ps;
    s_plv   = tlb_r.plv;
    s_mat   = tlb_r.mat;
    s_d     = tlb_r.d;
    s_v     = tlb_r.v;
  end

  function automatic res_t dut_resp(input int r);
    res_t x;
    case (r)
      0:       x = '{if_resp_found, if_resp_index, if_resp_ppn, if_resp_ps,
                     if_resp_plv, if_resp_mat, if_resp_d, if_resp_v};
      1:       x = '{mem_resp_found, mem_resp_index, mem_resp_ppn, mem_resp_ps,
                     mem_resp_plv, mem_resp_mat, mem_resp_d, mem_resp_v};
      default: x = '{srch_resp_found, srch_resp_index, srch_resp_ppn, srch_resp_ps,
                     srch_resp_plv, srch_resp_mat, srch_resp_d, srch_resp_v};
    endcase
    return x;
  endfunction

  function automatic logic [2:0] ready_v();
    return {srch_req_ready, mem_req_ready, if_req_ready};
  endfunction

  function automatic logic [2:0] valid_v();
    return {srch_resp_valid, mem_resp_valid, if_resp_valid};
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic apply(input logic [2:0] rv, input logic [2:0] rr, input logic busy,
                       input logic fl);
    {srch_req_valid, mem_req_valid, if_req_valid}    = rv;
    {srch_resp_ready, mem_resp_ready, if_resp_ready} = rr;
    tlb_busy = busy;
    flush    = fl;
  endtask

  task automatic do_reset();
    apply(3'b000, 3'b000, 1'b0, 1'b0);
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_req_ready", 64'(ready_v()), 64'd0);
    chk("reset_resp_valid", 64'(valid_v()), 64'd0);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  vec_t        tbl [18];
  logic [31:0] tva [3];
  logic [2:0]  mv;
  res_t        mp [3];
  int          last;
  res_t        held;

  initial begin
    n_err = 0; n_chk = 0;
    resetn = 1'b0; csr_asid = 10'h2A5; tb_salt = '0; tb_miss = 1'b0;
    if_va = 32'h1234_5000; mem_va = 32'h8000_2000; srch_va = 32'h0040_1000;
    apply(3'b000, 3'b000, 1'b0, 1'b0);
    #3;
    do_reset();

    // rv, rr, busy, flush, expected grant, expected valid after the edge ({srch,mem,if})
    tbl[0]  = '{3'b001, 3'b111, 1'b0, 1'b0, 3'b001, 3'b001};
    tbl[1]  = '{3'b011, 3'b111, 1'b0, 1'b0, 3'b010, 3'b010};
    tbl[2]  = '{3'b011, 3'b111, 1'b0, 1'b0, 3'b001, 3'b001};
    tbl[3]  = '{3'b111, 3'b111, 1'b0, 1'b0, 3'b100, 3'b100};
    tbl[4]  = '{3'b011, 3'b111, 1'b0, 1'b0, 3'b010, 3'b010};
    tbl[5]  = '{3'b011, 3'b111, 1'b0, 1'b0, 3'b001, 3'b001};
    tbl[6]  = '{3'b011, 3'b101, 1'b0, 1'b0, 3'b010, 3'b010};
    tbl[7]  = '{3'b011, 3'b101, 1'b0, 1'b0, 3'b001, 3'b011};
    tbl[8]  = '{3'b011, 3'b101, 1'b0, 1'b0, 3'b001, 3'b011};
    tbl[9]  = '{3'b011, 3'b111, 1'b0, 1'b0, 3'b010, 3'b010};
    tbl[10] = '{3'b111, 3'b111, 1'b1, 1'b0, 3'b000, 3'b000};
    tbl[11] = '{3'b111, 3'b111, 1'b1, 1'b0, 3'b000, 3'b000};
    tbl[12] = '{3'b111, 3'b111, 1'b1, 1'b0, 3'b000, 3'b000};
    tbl[13] = '{3'b111, 3'b111, 1'b0, 1'b0, 3'b100, 3'b100};
    tbl[14] = '{3'b001, 3'b000, 1'b0, 1'b0, 3'b001, 3'b101};
    tbl[15] = '{3'b010, 3'b000, 1'b0, 1'b0, 3'b010, 3'b111};
    tbl[16] = '{3'b111, 3'b000, 1'b0, 1'b1, 3'b000, 3'b100};
    tbl[17] = '{3'b000, 3'b111, 1'b0, 1'b0, 3'b000, 3'b000};

    held = '0;
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      apply(tbl[i].rv, tbl[i].rr, tbl[i].busy, tbl[i].flush);
      tb_salt = (i == 0) ? 20'h09B1E : 20'(i * 37);
      #1;
      chk($sformatf("tbl%0d_grant", i), 64'(ready_v()), 64'(tbl[i].gnt));
      if (tbl[i].gnt != 3'b000) begin
        logic [31:0] wva;
        wva = tbl[i].gnt[2] ? srch_va : (tbl[i].gnt[1] ? mem_va : if_va);
        chk($sformatf("tbl%0d_vppn", i), 64'({s_vppn, s_va_bit12}), 64'(wva[31:12]));
      end
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d_valid", i), 64'(valid_v()), 64'(tbl[i].vld));
      if (i == 0) begin
        chk("if_alone_vppn_hex", 64'(if_va[31:13]), 64'h091A2);
        chk("if_alone_ppn", 64'(if_resp_ppn), 64'h00ABC);
        chk("if_alone_ps", 64'(if_resp_ps), 64'd12);
        chk("if_alone_found", 64'(if_resp_found), 64'd1);
      end
      if (i == 6) held = dut_resp(1);
      if (i == 7 || i == 8) chk($sformatf("tbl%0d_mem_hold", i), 64'(dut_resp(1)), 64'(held));
    end
    chk("mem_hold_expected", 64'(held), 64'(tlb_model(mem_va[31:13], 20'(6 * 37), 1'b0)));

    // Miss on MEM, then asynchronous reset with IF and MEM slots full
    @(negedge clk);
    apply(3'b010, 3'b000, 1'b0, 1'b0);
    tb_miss = 1'b1; tb_salt = 20'h00005;
    #1;
    chk("miss_grant", 64'(ready_v()), 64'b010);
    @(posedge clk);
    #1;
    chk("miss_valid", 64'(mem_resp_valid), 64'd1);
    chk("miss_found", 64'(mem_resp_found), 64'd0);
    chk("miss_payload", 64'(dut_resp(1)), 64'(tlb_model(mem_va[31:13], 20'h00005, 1'b1)));
    @(negedge clk);
    apply(3'b001, 3'b000, 1'b0, 1'b0);
    tb_miss = 1'b0;
    @(posedge clk);
    #1;
    chk("prereset_valid", 64'(valid_v()), 64'b011);
    @(negedge clk);
    apply(3'b000, 3'b000, 1'b0, 1'b0);
    #1;
    resetn = 1'b0;
    #1;
    chk("async_reset_valid", 64'(valid_v()), 64'd0);
    chk("async_reset_ready", 64'(ready_v()), 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    apply(3'b011, 3'b111, 1'b0, 1'b0);
    #1;
    chk("reset_last_is_mem", 64'(ready_v()), 64'b001);

    // Randomized traffic against a slot-level model
    do_reset();
    mv = '0; last = 1;
    for (int c = 0; c < 3000; c++) begin
      logic [2:0] rv, rr, el;
      logic       busy, fl;
      int         win;
      @(negedge clk);
      rv   = 3'($urandom);
      rr   = 3'($urandom) | 3'($urandom);
      rv[2] = rv[2] & ($urandom_range(0, 3) == 0);
      busy = ($urandom_range(0, 9) == 0);
      fl   = ($urandom_range(0, 19) == 0);
      for (int r = 0; r < 3; r++) tva[r] = $urandom;
      if_va = tva[0]; mem_va = tva[1]; srch_va = tva[2];
      csr_asid = 10'($urandom);
      tb_salt  = 20'($urandom);
      tb_miss  = ($urandom_range(0, 7) == 0);
      apply(rv, rr, busy, fl);
      #1;
      for (int r = 0; r < 3; r++) el[r] = rv[r] && (!mv[r] || rr[r]) && !busy && !fl;
      if (el[2])             win = 2;
      else if (el[0] && el[1]) win = (last == 0) ? 1 : 0;
      else if (el[0])        win = 0;
      else if (el[1])        win = 1;
      else                   win = -1;
      chk("rnd_grant", 64'(ready_v()), (win < 0) ? 64'd0 : (64'd1 << win));
      if (win >= 0) chk("rnd_vppn", 64'({s_vppn, s_va_bit12}), 64'(tva[win][31:12]));
      chk("rnd_asid", 64'(s_asid), 64'(csr_asid));
      chk("rnd_valid", 64'(valid_v()), 64'(mv));
      for (int r = 0; r < 3; r++)
        if (mv[r]) chk($sformatf("rnd_payload%0d", r), 64'(dut_resp(r)), 64'(mp[r]));
      @(posedge clk);
      for (int r = 0; r < 3; r++) begin
        if (r == win) begin
          mv[r] = 1'b1;
          mp[r] = tlb_model(tva[r][31:13], tb_salt, tb_miss);
        end else if (mv[r] && rr[r]) begin
          mv[r] = 1'b0;
        end
      end
      if (fl) mv[1:0] = 2'b00;
      if (win == 0 || win == 1) last = win;
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got=running expected=done");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mmu_tlb_arbiter.md
# mmu_tlb_arbiter

Shares the single TLB search port among three requesters: instruction fetch (IF), data load/store (MEM), and the `tlbsrch` CSR instruction (SRCH). Each cycle it grants at most one requester, drives the TLB search inputs, and captures the combinational search result into a one-entry response slot per requester. Each requester's `MMU_convert` instance consumes the slot contents. The block sits between the pipeline stages and the TLB array.

## Interface
- `TLBNUM`, default 16: TLB entry count; index width is `$clog2(TLBNUM)`.

Ports:
- `clk` in 1: clock.
- `resetn` in 1: asynchronous, active-low reset.
- `csr_asid` in 10: current ASID, driven onto `s_asid`.
- `tlb_busy` in 1: TLB write or `invtlb` in progress; blocks all grants.
- `flush` in 1: pipeline flush; blocks grants and drops IF/MEM slots.
- `{if,mem,srch}_req_valid` in 1 each: request.
- `{if,mem,srch}_va` in 32 each: virtual address to look up.
- `{if,mem,srch}_req_ready` out 1 each: grant; handshake completes on `valid & ready`.
- `{if,mem,srch}_resp_valid` out 1 each: slot holds a result.
- `{if,mem,srch}_resp_ready` in 1 each: requester consumes the slot.
- `{if,mem,srch}_resp_*` out: slot payload, one set per requester:
  - `found` 1
  - `index` log2
  - `ppn` 20
  - `ps` 6
  - `plv` 2
  - `mat` 2
  - `d` 1
  - `v` 1
- `s_vppn` out 19, `s_va_bit12` out 1, `s_asid` out 10: TLB search inputs.
- `s_found`, `s_index`, `s_ppn`, `s_ps`, `s_plv`, `s_mat`, `s_d`, `s_v` in: TLB search result, combinational in the same cycle.

## Operation
- Eligibility: requester r is eligible when `r_req_valid`, and its slot is either empty or being consumed this cycle (`r_resp_valid & r_resp_ready`), and `~tlb_busy & ~flush`.
- Priority:
  - SRCH is highest.
  - IF vs MEM is round-robin on pointer `last`. The one not equal to `last` wins a tie.
  - `last` resets to MEM, so IF wins the first tie.
  - `last` updates only on IF/MEM grants.
- Exactly one `*_req_ready` is high per cycle, or none. `req_ready` is combinational from eligibility and does not depend on the winner's `req_valid` beyond eligibility.
- Search drive:
  - `s_vppn = va[31:13]` and `s_va_bit12 = va[12]` of the winner.
  - With no grant, the IF va is driven; don't-care.
  - `s_asid = csr_asid` always.
- Slot update on each clock edge, per requester:
  - If granted: load the TLB result and set valid.
  - Else if `resp_ready & resp_valid`: clear valid.
  - `flush` clears IF and MEM valid, overriding a load; it never clears SRCH.
- Payload is held stable while valid. Payload registers are not reset, only the valid bits.

## Timing
- Reset:
  - All `resp_valid` = 0.
  - All `req_ready` = 0, because slots are empty but `req_valid` is 0.
  - `last` = MEM.
  - Reset mid-operation discards all slots immediately.
- Latency: grant in cycle N → `resp_valid` high in N+1 with that cycle's TLB result.
- Throughput: one search per cycle. A requester that holds `resp_ready` high is granted every cycle when it wins arbitration.
- `tlb_busy` is sampled combinationally. A search in the cycle `tlb_busy` falls is allowed, and the result reflects the updated TLB.
- `flush` and grant in the same cycle: no grant. `flush` while a slot is valid: the slot is invalid in the next cycle regardless of `resp_ready`.
- SRCH starvation of IF/MEM is bounded by the pipeline, because `tlbsrch` is serialized. No additional fairness is required.

## Structure
- Shared `macro.vh` additions:
  - `TLB_RES_W = 33 + $clog2(TLBNUM)` (1+20+6+2+2+1+1 = 33 bits plus the index).
  - Requester ID defines `REQ_IF` = 0, `REQ_MEM` = 1, `REQ_SRCH` = 2.
- Sub-module `mmu_resp_slot`: one-entry valid/payload buffer with inputs `load`, `consume`, `kill`, instantiated three times. SRCH has `kill` tied to 0.
- The arbiter core (eligibility, priority, `last` pointer, search mux) lives in `mmu_tlb_arbiter`.

## Test plan
- **Reset, then IF alone.** Stimulus: `if_va=0x1234_5000`, TLB hit with `ppn=0x00ABC`, `ps=12`. Response: `if_req_ready` high in cycle 0; `s_vppn=0x091A2`, `s_va_bit12=1`; `if_resp_valid` in cycle 1 with `ppn=0x00ABC`.
- **IF and MEM requesting continuously, both `resp_ready` high.** Response: grants alternate IF, MEM, IF, MEM…, starting with IF. Add `srch_req_valid` for one cycle: SRCH wins that cycle and the alternation resumes.
- **Backpressure.** Stimulus: `mem_resp_ready=0` after the first MEM response. Response: no further MEM grant; IF is still granted every cycle; the MEM payload stays unchanged. Raising `mem_resp_ready` allows a grant in that same cycle.
- **`tlb_busy` for 3 cycles with all requesters valid.** Response: zero grants in those cycles; SRCH is granted in the first cycle after `tlb_busy` falls.
- **`flush` with IF, MEM and SRCH slots all valid and `resp_ready=0`.** Response: next cycle IF and MEM are invalid, SRCH is still valid; no grant during the flush cycle.
- **Miss, then reset mid-operation.** Stimulus: `s_found=0` for a MEM request. Response: `mem_resp_found=0` with valid asserted. Then asserting `resetn=0` drops all `resp_valid` asynchronously, and `last` returns to MEM.
